// File: rtl/ising_phase_reader_if.sv
// Read-strobe bus between software and the oscillator phase reader.
// Master issues rready/rd_addr; slave returns rdata/rvalid one cycle later.
interface ising_phase_reader_if;
  logic        rready;
  logic [31:0] rd_addr;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output rready, output rd_addr, input rdata, input rvalid);
  modport slave  (input rready, input rd_addr, output rdata, output rvalid);
endinterface

// File: rtl/ising_phase_reader.sv
// Oscillator phase readout: synchronizes N oscillators, counts disagreements with
// oscillator 0 over a fixed window, and exposes status/counts/spins through a 1-cycle read port.
module ising_phase_reader #(
  parameter int          N             = 3,
  parameter int          SETTLE_CYCLES = 64,
  parameter int          COUNT_CYCLES  = 1024,
  parameter logic [31:0] ADDR_BASE     = 32'h0000_2000
) (
  input  logic                   clk,
  input  logic                   axi_rstn,
  input  logic [N-1:0]           osc_in,
  input  logic                   start,
  ising_phase_reader_if.slave    rd,
  output logic                   busy,
  output logic                   done
);

  localparam int CW   = $clog2(COUNT_CYCLES + 1);
  localparam int TMAX = (SETTLE_CYCLES > COUNT_CYCLES) ? SETTLE_CYCLES : COUNT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [N-1:0]    meta_q, osc_s_q, mm, spin;
  logic [CW-1:0]   cnt_q [N];
  logic [CW-1:0]   cnt_d [N];
  logic            clr_cnt, cnt_en, busy_d, done_d, busy_q, done_q;
  logic [31:0]     off, rdata_d, rdata_q;
  logic [29:0]     k;
  logic            rvalid_q;

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      meta_q  <= '0;
      osc_s_q <= '0;
    end else begin
      meta_q  <= osc_in;
      osc_s_q <= meta_q;
    end
  end

  assign mm = osc_s_q ^ {N{osc_s_q[0]}};

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          tcnt_d  = '0;
        end
      end
      SETTLE: begin
        if (tcnt_q == TW'(SETTLE_CYCLES - 1)) begin
          state_d = COUNT;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      COUNT: begin
        if (tcnt_q == TW'(COUNT_CYCLES - 1)) begin
          state_d = DONE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy/done decode the next state so they line up with the state register itself
  always_comb begin
    clr_cnt = start && ((state_q == IDLE) || (state_q == DONE));
    cnt_en  = (state_q == COUNT);
    busy_d  = (state_d == SETTLE) || (state_d == COUNT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_cnt)
        cnt_d[i] = '0;
      else if (cnt_en && mm[i])
        cnt_d[i] = cnt_q[i] + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    spin = '0;
    for (int i = 1; i < N; i++)
      spin[i] = (cnt_q[i] > CW'(COUNT_CYCLES / 2));
  end

  // Reads sample the registered counts, so a same-cycle increment or clear is not visible yet
  always_comb begin
    off     = rd.rd_addr - ADDR_BASE;
    k       = off[31:2];
    rdata_d = '0;
    if ((rd.rd_addr >= ADDR_BASE) && (off[1:0] == 2'b00)) begin
      if (k == 30'd0)
        rdata_d = {30'b0, done_q, busy_q};
      else if (k == 30'(N + 1))
        rdata_d = 32'(spin);
      for (int i = 0; i < N; i++)
        if (k == 30'(i + 1))
          rdata_d = 32'(cnt_q[i]);
    end
  end

  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd.rready;
      if (rd.rready)
        rdata_q <= rdata_d;
    end
  end

  assign rd.rdata  = rdata_q;
  assign rd.rvalid = rvalid_q;

endmodule

// File: tb/tb_ising_phase_reader.sv
// Scoreboard bench for ising_phase_reader with N=3, SETTLE=4, COUNT=16.
module tb_ising_phase_reader;
  localparam int          N = 3;
  localparam int          S = 4;
  localparam int          C = 16;
  localparam logic [31:0] B = 32'h0000_2000;

  logic         clk = 1'b0;
  logic         axi_rstn = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] osc_in;
  logic [N-1:0] osc_man = '0;
  logic [1:0]   mode = 2'd0;
  logic [2:0]   ph = '0;
  logic         busy, done;

  ising_phase_reader_if rif ();

  ising_phase_reader #(
    .N(N), .SETTLE_CYCLES(S), .COUNT_CYCLES(C), .ADDR_BASE(B)
  ) dut (
    .clk(clk), .axi_rstn(axi_rstn), .osc_in(osc_in), .start(start),
    .rd(rif.slave), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // 8-cycle square wave source; mode 0 = hand-driven, 1 = in-phase, 2 = osc2 inverted
  always @(posedge clk) ph <= ph + 3'd1;
  assign osc_in = (mode == 2'd0) ? osc_man :
                  (mode == 2'd1) ? {ph[2], ph[2], ph[2]} : {~ph[2], ph[2], ph[2]};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rif.rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: got rvalid=1 with rdata 0x%08h, expected no read pending", rif.rdata);
      end else begin
        check(name_q.pop_front(), rif.rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    rif.rd_addr = a;
    rif.rready  = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
    rif.rready  = 1'b0;
  endtask

  // start pulse, optional spurious start at tick `spur`, optional osc1 mismatch of `len` samples
  task automatic measure(input string tag, input int spur, input int len);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_t1"}, 32'(busy), 32'd1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      if (len > 0 && cyc == 7)       osc_man[1] = 1'b1;
      if (len > 0 && cyc == 7 + len) osc_man[1] = 1'b0;
      start = (cyc == spur);
      tick();
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done_latency"}, 32'(cyc), 32'd21);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic read_all(input string tag, input logic [31:0] c0, input logic [31:0] c1,
                          input logic [31:0] c2, input logic [31:0] sp);
    rd(B + 32'd4,  c0, {tag, "_cnt0"});
    rd(B + 32'd8,  c1, {tag, "_cnt1"});
    rd(B + 32'd12, c2, {tag, "_cnt2"});
    rd(B + 32'd16, sp, {tag, "_spin"});
    rd(B,          32'd2, {tag, "_status"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.rready  = 1'b0;
    rif.rd_addr = '0;
    repeat (3) tick();
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_done",   32'(done), 32'd0);
    check("rst_rvalid", 32'(rif.rvalid), 32'd0);
    check("rst_rdata",  rif.rdata, 32'd0);
    axi_rstn = 1'b1;
    tick();
    rd(B,          32'd0, "rst_status");
    rd(B + 32'd4,  32'd0, "rst_cnt0");
    rd(B + 32'd8,  32'd0, "rst_cnt1");
    tick();

    mode = 2'd1;
    repeat (4) tick();
    measure("inphase", 0, 0);
    read_all("inphase", 32'd0, 32'd0, 32'd0, 32'd0);

    mode = 2'd2;
    repeat (4) tick();
    measure("anti", 0, 0);
    read_all("anti", 32'd0, 32'd0, 32'd16, 32'd4);

    mode    = 2'd0;
    osc_man = '0;
    repeat (4) tick();
    measure("thr8", 0, 8);
    read_all("thr8", 32'd0, 32'd8, 32'd0, 32'd0);

    measure("thr9_spur", 10, 9);
    read_all("thr9", 32'd0, 32'd9, 32'd0, 32'd2);

    start = 1'b1;
    rd(B + 32'd8, 32'd9, "restart_same_cycle_cnt1");
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    rd(B + 32'd8, 32'd0, "restart_next_cycle_cnt1");
    rd(B,         32'd1, "restart_status_busy");

    mode = 2'd2;
    repeat (8) tick();
    axi_rstn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) tick();
    axi_rstn = 1'b1;
    tick();
    rd(B + 32'd12, 32'd0, "midrst_cnt2");
    rd(B,          32'd0, "midrst_status");

    rd(B + 32'd20, 32'd0, "unmapped_k5");
    rd(B + 32'd2,  32'd0, "misaligned");
    rd(B - 32'd4,  32'd0, "below_base");
    rd(B + 32'd4,  32'd0, "b2b_cnt0");
    repeat (3) tick();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ising_phase_reader.md
# ising_phase_reader

Readout block for the oscillator array, the read-side counterpart of the weight-write path. Synchronizes the N oscillator outputs into `clk`, measures over a fixed window how often each oscillator disagrees with oscillator 0, and derives a spin bitmap from those counts. Software reads status, per-oscillator mismatch counts and the spin bitmap through an address-matched read strobe.

## Interface
- `N`, 3: number of oscillators; 2 ≤ N ≤ 32.
- `SETTLE_CYCLES`, 64: `clk` cycles ignored after `start` before counting; ≥ 1.
- `COUNT_CYCLES`, 1024: length of the counting window in `clk` cycles; ≥ 2.
- `ADDR_BASE`, 32'h0000_2000: byte address of word 0 of the read map.
- `clk` in 1: single system clock; every register is clocked on its rising edge.
- `axi_rstn` in 1: reset, asynchronous assert, active-low.
- `osc_in` in N: raw oscillator outputs, asynchronous to `clk`.
- `start` in 1: one-cycle pulse that begins a measurement.
- `rready` in 1: one-cycle read strobe; `rd_addr` is valid in the same cycle.
- `rd_addr` in 32: byte read address.
- `rdata` out 32: read data.
- `rvalid` out 1: one-cycle pulse marking `rdata` valid.
- `busy` out 1: high in SETTLE and COUNT.
- `done` out 1: high in DONE.

## Operation
- Synchronizer: two flops per bit, `osc_s[i]`. Only `osc_s` feeds any logic.
- Mismatch: `mm[i] = osc_s[i] ^ osc_s[0]`. `mm[0]` is always 0.
- Counters: `cnt[i]` is `$clog2(COUNT_CYCLES+1)` bits wide, zero-extended to 32 bits when read. A counter increments in every COUNT cycle where `mm[i]` is 1. It cannot overflow, so there is no saturation.
- Spin: `spin[i] = (cnt[i] > COUNT_CYCLES/2)`, integer division, computed combinationally from `cnt`. `spin[0]` is always 0.
- FSM states, with a cycle counter `tcnt`:
  - IDLE: on `start`, clear all `cnt`, clear `tcnt`, go to SETTLE.
  - SETTLE: `tcnt` increments. When `tcnt == SETTLE_CYCLES-1`, clear `tcnt` and go to COUNT.
  - COUNT: counters accumulate and `tcnt` increments. When `tcnt == COUNT_CYCLES-1`, that cycle's sample still counts; then go to DONE.
  - DONE: hold all counts. On `start`, behave exactly as IDLE on `start`.
- `start` is ignored in SETTLE and COUNT.
- Read map, word offset `k = (rd_addr - ADDR_BASE)/4`:
  - k=0: status word = {30'b0, done, busy}.
  - k=1..N: `cnt[k-1]`.
  - k=N+1: spin bitmap, bit i = `spin[i]`, upper bits 0.
  - Any other address, including a misaligned or below-base address: 32'h0.
- Every `rready` produces exactly one `rvalid`, including reads to unmapped addresses.
- Reads are legal in any state. During COUNT a read returns the live count.

## Timing
- Reset values: all `cnt` = 0, `tcnt` = 0, FSM = IDLE, `osc_s` = 0, `rdata` = 0, `rvalid` = 0, `busy` = 0, `done` = 0.
- `busy` and `done` are registered state decodes.
  - `start` in cycle t → `busy` high from t+1.
  - First counted sample is at cycle t+1+SETTLE_CYCLES.
  - `done` rises at t+1+SETTLE_CYCLES+COUNT_CYCLES.
- Synchronizer latency is 2 cycles. An `osc_in` edge affects counting 2 cycles later.
- Read latency is 1 cycle: `rready` at t → `rvalid` and `rdata` at t+1.
  - `rdata` holds its value until the next read.
  - `rvalid` is high for exactly 1 cycle per strobe.
  - Back-to-back strobes give back-to-back `rvalid` pulses.
- A read in the same cycle as a counter increment returns the pre-increment value.
- A read in the same cycle as `start` from DONE returns the old counts. A read in the following cycle returns 0.
- If `axi_rstn` asserts mid-measurement, the block returns immediately to reset values. A pending `rvalid` is dropped.

## Test plan
- **Reset values:** reset, then read status → `rvalid` one cycle after `rready`, `rdata` = 0; reading k=1 returns 0.
- **In-phase oscillators:** N=3, SETTLE_CYCLES=4, COUNT_CYCLES=16, all three oscillators driven by an identical 8-cycle square wave; `start` → `done` rises 21 cycles after `start`. Counts read 0, 0, 0 and spin = 3'b000.
- **Anti-phase oscillator:** `osc_in[2]` = `~osc_in[0]`, `osc_in[1]` = `osc_in[0]`, same parameters → `cnt[2]` = 16, `cnt[1]` = 0, spin = 3'b100.
- **Threshold boundary:** force `mm[1]` high for exactly 8 of the 16 COUNT cycles → spin[1] = 0. At 9 cycles → spin[1] = 1.
- **`start` handling:**
  - Pulse `start` during COUNT → ignored; `done` timing is unchanged.
  - Pulse `start` in DONE → counts cleared the next cycle and `busy` = 1.
- **Unmapped read and reset mid-run:**
  - Read `ADDR_BASE` + 4*(N+2) → `rdata` = 0 with `rvalid` still pulsed.
  - Assert `axi_rstn` mid-COUNT → `busy` = 0 and `done` = 0 immediately, and counts read 0 after release.
